// File: rtl/serial_operand_rx_if.sv
// serial_operand_rx_if: serial frame input and deserialised operand/status bundle
interface serial_operand_rx_if #(parameter int OP_W = 4);
  logic            serial_in;
  logic            shift_enable;
  logic [OP_W-1:0] A;
  logic [OP_W-1:0] B;
  logic            sipo_done;
  logic            frame_err;
  logic            busy;
  modport master (output serial_in, shift_enable, input A, B, sipo_done, frame_err, busy);
  modport slave  (input serial_in, shift_enable, output A, B, sipo_done, frame_err, busy);
endinterface

// File: rtl/serial_operand_rx.sv
// serial_operand_rx: framed serial receiver that deserialises operands A and B with optional even parity
module serial_operand_rx #(
  parameter int OP_W      = 4,
  parameter bit PARITY_EN = 1
) (
  input logic                clk,
  input logic                reset,
  serial_operand_rx_if.slave sif
);
  localparam int N  = 2 * OP_W;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] FULL = CW'(N);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_sr;
  logic            r_par;
  logic [OP_W-1:0] r_a, r_b;
  logic            r_done, r_err, r_busy;
  logic            w_par_ok;
  assign w_par_ok = ~(^r_sr ^ r_par);
  // The accept/reject decision is taken one edge after the last sampled bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_par   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: if (sif.shift_enable && sif.serial_in) begin
          r_state <= SHIFT;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
        SHIFT: if (!sif.shift_enable) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end else if (r_cnt != FULL) begin
          r_sr  <= {sif.serial_in, r_sr[N-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (PARITY_EN && r_cnt == LAST) r_state <= PARITY;
        end else begin
          r_state <= DONE;
          r_a     <= r_sr[OP_W-1:0];
          r_b     <= r_sr[N-1:OP_W];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        PARITY: if (!sif.shift_enable) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end else if (r_cnt == FULL) begin
          r_par <= sif.serial_in;
          r_cnt <= r_cnt + 1'b1;
        end else if (w_par_ok) begin
          r_state <= DONE;
          r_a     <= r_sr[OP_W-1:0];
          r_b     <= r_sr[N-1:OP_W];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end else begin
          r_state <= IDLE;
          r_err   <= 1'b1;
          r_busy  <= 1'b0;
        end
        DONE: if (!sif.shift_enable) begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
  assign sif.A         = r_a;
  assign sif.B         = r_b;
  assign sif.sipo_done = r_done;
  assign sif.frame_err = r_err;
  assign sif.busy      = r_busy;
endmodule

// File: tb/tb_serial_operand_rx.sv
// tb_serial_operand_rx: randomized scoreboard bench for serial_operand_rx
module tb_serial_operand_rx;
  localparam int W = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  serial_operand_rx_if #(.OP_W(W)) sif();
  serial_operand_rx #(.OP_W(W), .PARITY_EN(1)) dut (.clk(clk), .reset(reset), .sif(sif));
  typedef struct {
    bit           err;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           cyc;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_done = 1'b0;
  logic [W-1:0] last_a = '0;
  logic [W-1:0] last_b = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  // Monitor: every accepted frame or parity error is matched against the scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && ((sif.sipo_done && !prev_done) || sif.frame_err)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: done=%0b err=%0b with nothing expected", sif.sipo_done, sif.frame_err);
      end else begin
        e = q.pop_front();
        check("event_err", sif.frame_err, e.err);
        check("event_done", sif.sipo_done, !e.err);
        check("event_A", sif.A, e.a);
        check("event_B", sif.B, e.b);
        check("event_cycle", cyc, e.cyc);
      end
    end
    prev_done <= reset ? sif.sipo_done : 1'b0;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Sends start + A + B + parity; abort_at>=0 drops shift_enable before that bit
  task automatic frame(logic [W-1:0] a, logic [W-1:0] b, bit bad, int abort_at, int hold);
    logic [2*W+1:0] bits;
    int e0;
    bits = {(^{a, b}) ^ bad, b, a, 1'b1};
    e0 = cyc + 1;
    sif.shift_enable = 1'b1;
    if (abort_at < 0) begin
      if (bad) q.push_back('{1'b1, last_a, last_b, e0 + 2 * W + 2});
      else begin
        q.push_back('{1'b0, a, b, e0 + 2 * W + 2});
        last_a = a;
        last_b = b;
      end
    end
    for (int i = 0; i < 2 * W + 2; i++) begin
      if (i == abort_at) begin
        sif.shift_enable = 1'b0;
        sif.serial_in = 1'($urandom);
        tick();
        check("abort_busy", sif.busy, 0);
        check("abort_done", sif.sipo_done, 0);
        sif.serial_in = 1'b0;
        tick();
        return;
      end
      sif.serial_in = bits[i];
      tick();
      check("busy_in_frame", sif.busy, 1);
    end
    sif.serial_in = 1'b0;
    tick();
    check("busy_after", sif.busy, 0);
    check("done_level", sif.sipo_done, !bad);
    if (!bad) begin
      for (int h = 0; h < hold; h++) begin
        sif.serial_in = 1'($urandom);
        tick();
        check("hold_done", sif.sipo_done, 1);
        check("hold_A", sif.A, a);
        check("hold_B", sif.B, b);
        check("hold_busy", sif.busy, 0);
      end
    end else begin
      check("err_keep_A", sif.A, last_a);
      check("err_keep_B", sif.B, last_b);
    end
    sif.shift_enable = 1'b0;
    sif.serial_in = 1'($urandom);
    tick();
    check("done_fall", sif.sipo_done, 0);
    sif.serial_in = 1'b0;
  endtask
  initial begin
    int ab;
    sif.serial_in = 1'b0;
    sif.shift_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sif.serial_in = ~sif.serial_in;
      tick();
      check("rst_outputs", {sif.A, sif.B, sif.sipo_done, sif.frame_err, sif.busy}, 0);
    end
    sif.shift_enable = 1'b0;
    sif.serial_in = 1'b1;
    reset = 1'b1;
    tick();
    check("post_rst_outputs", {sif.A, sif.B, sif.sipo_done, sif.frame_err, sif.busy}, 0);
    sif.serial_in = 1'b0;
    frame(4'hB, 4'h6, 1'b0, -1, 5);
    frame(4'hB, 4'h6, 1'b1, -1, 0);
    frame(4'h9, 4'h2, 1'b0, 4, 0);
    frame(4'h3, 4'hF, 1'b0, -1, 1);
    sif.shift_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sif.serial_in = (i == 0) ? 1'b1 : 1'($urandom);
      tick();
    end
    #2 reset = 1'b0;
    #1;
    check("async_rst", {sif.A, sif.B, sif.sipo_done, sif.frame_err, sif.busy}, 0);
    last_a = '0;
    last_b = '0;
    sif.shift_enable = 1'b0;
    sif.serial_in = 1'b0;
    #1 reset = 1'b1;
    tick();
    frame(4'hA, 4'h5, 1'b0, -1, 2);
    for (int n = 0; n < 30; n++) begin
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2 * W + 1)) : -1;
      frame(W'($urandom), W'($urandom), $urandom_range(0, 3) == 0, ab, $urandom_range(0, 4));
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
